// File: rtl/adj_clock_divider_ctrl.sv
// Adjustable clock divider controller with a factor handshake.
// ClkOutput toggles every ActiveFactor+1 ClkInput cycles while running.
// A new factor offered while running is held as pending and takes effect at the
// next toggle, so no half-period ever mixes two factors. Dropping Enable stops
// the output cleanly: a low phase stops at once, a high phase completes first.
// Optional feature: define ADJ_CLOCK_DIVIDER_CTRL_EDGE_CNT_EN to add EdgeCount.
// Ports:
//   ClkInput   - clock, rising edge
//   ResetN     - asynchronous active-low reset
//   Enable     - 1 = run divider, 0 = stop cleanly
//   CfgValid   - new factor offered
//   CfgFactor  - offered factor
//   CfgReady   - factor accepted this cycle (IDLE, RUN)
//   ClkOutput  - divided clock, registered
//   Tick       - one-cycle pulse in the cycle ClkOutput changes
//   Busy       - controller is not IDLE
//   EdgeCount  - (optional) 16-bit count of Ticks, wrapping
module adj_clock_divider_ctrl #(
  parameter int unsigned INPUT_BIT_WIDTH = 8,
  parameter int unsigned RESET_FACTOR    = 255
) (
  input  logic                       ClkInput,
  input  logic                       ResetN,
  input  logic                       Enable,
  input  logic                       CfgValid,
  input  logic [INPUT_BIT_WIDTH-1:0] CfgFactor,
  output logic                       CfgReady,
  output logic                       ClkOutput,
  output logic                       Tick,
  output logic                       Busy
`ifdef ADJ_CLOCK_DIVIDER_CTRL_EDGE_CNT_EN
  ,
  output logic [15:0]                EdgeCount
`endif
);

  localparam int unsigned W = INPUT_BIT_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PEND  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   active_q, active_d;
  logic [W-1:0]   pending_q, pending_d;
  logic           pend_q, pend_d;
  logic           clk_out_q, clk_out_d;
  logic           tick_q, tick_d;
  logic           busy_q, busy_d;
  logic           ready_q, ready_d;

  logic           xfer;
  logic           due;

  assign xfer = CfgValid && ready_q;
  // Counter never exceeds active_q, so a factor of 2^W-1 cannot overflow it.
  assign due  = (cnt_q >= active_q);

  // State and datapath registers
  always_ff @(posedge ClkInput or negedge ResetN) begin
    if (!ResetN) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      active_q  <= W'(RESET_FACTOR);
      pending_q <= '0;
      pend_q    <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      pend_q    <= pend_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    active_d  = active_q;
    pending_d = pending_q;
    pend_d    = pend_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d     = '0;
        clk_out_d = 1'b0;
        // Factor is written before RUN starts, so a coincident Enable uses it.
        if (xfer) active_d = CfgFactor;
        if (Enable) state_d = RUN;
      end

      RUN, PEND: begin
        if (state_q == RUN && xfer) begin
          pending_d = CfgFactor;
          pend_d    = 1'b1;
          state_d   = PEND;
        end
        if (!Enable && !clk_out_q) begin
          // Low phase: stop immediately without a toggle.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (due) begin
          cnt_d     = '0;
          clk_out_d = !clk_out_q;
          tick_d    = 1'b1;
          if (!Enable) begin
            state_d = IDLE;
          end else if (state_q == PEND) begin
            active_d = pending_q;
            pend_d   = 1'b0;
            state_d  = RUN;
          end
        end else begin
          cnt_d = cnt_q + W'(1);
          if (!Enable) state_d = DRAIN;
        end
      end

      DRAIN: begin
        // High phase runs to full length with the old factor, then 1->0.
        if (due) begin
          cnt_d     = '0;
          clk_out_d = 1'b0;
          tick_d    = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // A pending factor is never dropped: apply it on the way into IDLE.
    if (state_d == IDLE && pend_d) begin
      active_d = pending_d;
      pend_d   = 1'b0;
    end

    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE) || (state_d == RUN);
  end

  assign ClkOutput = clk_out_q;
  assign Tick      = tick_q;
  assign Busy      = busy_q;
  assign CfgReady  = ready_q;

`ifdef ADJ_CLOCK_DIVIDER_CTRL_EDGE_CNT_EN
  logic [15:0] edge_cnt_q;

  // Counts Ticks; advances on the same edge Tick rises, wraps naturally.
  always_ff @(posedge ClkInput or negedge ResetN) begin
    if (!ResetN) begin
      edge_cnt_q <= '0;
    end else if (tick_d) begin
      edge_cnt_q <= edge_cnt_q + 16'd1;
    end
  end

  assign EdgeCount = edge_cnt_q;
`endif

endmodule

// File: tb/tb_adj_clock_divider_ctrl.sv
// Directed self-checking bench for adj_clock_divider_ctrl.
module tb_adj_clock_divider_ctrl;

  localparam int unsigned W = 8;
  localparam int unsigned LIMIT = 1000;

  logic         clk;
  logic         rst_n;
  logic         enable;
  logic         cfg_valid;
  logic [W-1:0] cfg_factor;
  logic         cfg_ready;
  logic         clk_out;
  logic         tick;
  logic         busy;
`ifdef ADJ_CLOCK_DIVIDER_CTRL_EDGE_CNT_EN
  logic [15:0]  edge_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int cyc;

  adj_clock_divider_ctrl #(
    .INPUT_BIT_WIDTH (W),
    .RESET_FACTOR    (255)
  ) dut (
    .ClkInput  (clk),
    .ResetN    (rst_n),
    .Enable    (enable),
    .CfgValid  (cfg_valid),
    .CfgFactor (cfg_factor),
    .CfgReady  (cfg_ready),
    .ClkOutput (clk_out),
    .Tick      (tick),
    .Busy      (busy)
`ifdef ADJ_CLOCK_DIVIDER_CTRL_EDGE_CNT_EN
    ,
    .EdgeCount (edge_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count cycles until ClkOutput reaches lvl; an expired bound is a failure.
  task automatic wait_lvl(input logic lvl, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (clk_out !== lvl && n < LIMIT);
    if (clk_out !== lvl) check("timeout", 32'(n), 32'(LIMIT + 1));
  endtask

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b0;
    cfg_valid  = 1'b0;
    cfg_factor = '0;
    #12;
    check("rst_clk_out", 32'(clk_out), 0);
    check("rst_tick", 32'(tick), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(cfg_ready), 1);
    step();
    rst_n = 1'b1;

    // Factor 3 through the IDLE handshake, then run
    cfg_valid = 1'b1; cfg_factor = 8'd3;
    step();
    cfg_valid = 1'b0; enable = 1'b1;
    step();
    check("run_busy", 32'(busy), 1);
    wait_lvl(1'b1, cyc); check("f3_first_rise", 32'(cyc), 4);
    check("f3_tick_hi", 32'(tick), 1);
    wait_lvl(1'b0, cyc); check("f3_high", 32'(cyc), 4);
    wait_lvl(1'b1, cyc); check("f3_low", 32'(cyc), 4);

    // Factor 1 offered mid-high-phase while running factor 3
    step();
    check("f3_tick_lo", 32'(tick), 0);
    check("run_ready", 32'(cfg_ready), 1);
    cfg_valid = 1'b1; cfg_factor = 8'd1;
    step();
    cfg_valid = 1'b0;
    check("pend_ready", 32'(cfg_ready), 0);
    wait_lvl(1'b0, cyc); check("pend_high_rest", 32'(cyc), 2);
    check("ready_after_apply", 32'(cfg_ready), 1);
    wait_lvl(1'b1, cyc); check("f1_low", 32'(cyc), 2);
    wait_lvl(1'b0, cyc); check("f1_high", 32'(cyc), 2);

    // Factor 0 (divide by 2), then factor 255
    cfg_valid = 1'b1; cfg_factor = 8'd0;
    step();
    cfg_valid = 1'b0;
    wait_lvl(1'b1, cyc); check("f0_apply", 32'(cyc), 1);
    wait_lvl(1'b0, cyc); check("f0_high", 32'(cyc), 1);
    wait_lvl(1'b1, cyc); check("f0_low", 32'(cyc), 1);
    cfg_valid = 1'b1; cfg_factor = 8'd255;
    step();
    cfg_valid = 1'b0;
    check("f0_toggle_on_xfer", 32'(clk_out), 0);
    wait_lvl(1'b1, cyc); check("f255_apply", 32'(cyc), 1);
    wait_lvl(1'b0, cyc); check("f255_high", 32'(cyc), 256);
    wait_lvl(1'b1, cyc); check("f255_low", 32'(cyc), 256);
    wait_lvl(1'b0, cyc);

    // Enable dropped during low phase: IDLE next cycle, no toggle
    enable = 1'b0;
    step();
    check("lowstop_busy", 32'(busy), 0);
    check("lowstop_clk", 32'(clk_out), 0);
    check("lowstop_tick", 32'(tick), 0);

    // Factor 5 handshake coincident with Enable rising in IDLE
    cfg_valid = 1'b1; cfg_factor = 8'd5; enable = 1'b1;
    step();
    cfg_valid = 1'b0;
    wait_lvl(1'b1, cyc); check("f5_first_rise", 32'(cyc), 6);
    step();
    enable = 1'b0;
    wait_lvl(1'b0, cyc); check("drain_high_rest", 32'(cyc), 5);
    check("drain_busy_after", 32'(busy), 0);
    step();
    check("drain_idle_clk", 32'(clk_out), 0);

    // Enable returning during DRAIN is ignored until IDLE
    enable = 1'b1;
    wait_lvl(1'b1, cyc); check("rerun_rise", 32'(cyc), 7);
    step();
    enable = 1'b0;
    step();
    enable = 1'b1;
    wait_lvl(1'b0, cyc); check("drain2_rest", 32'(cyc), 4);
    check("drain2_idle", 32'(busy), 0);
    wait_lvl(1'b1, cyc); check("drain2_restart", 32'(cyc), 7);

    // Asynchronous reset mid-high-phase
    step();
    step();
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_clk", 32'(clk_out), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_ready", 32'(cfg_ready), 1);
    #2;
    rst_n = 1'b1;
    check("arst_hold", 32'(busy), 0);
    wait_lvl(1'b1, cyc); check("arst_factor255", 32'(cyc), 257);

`ifdef ADJ_CLOCK_DIVIDER_CTRL_EDGE_CNT_EN
    // EdgeCount wraps after 65537 ticks at factor 0
    rst_n = 1'b0; enable = 1'b0;
    step();
    rst_n = 1'b1;
    check("ec_reset", 32'(edge_count), 0);
    cfg_valid = 1'b1; cfg_factor = 8'd0; enable = 1'b1;
    step();
    cfg_valid = 1'b0;
    for (int i = 0; i < 65537; i++) step();
    check("ec_wrap", 32'(edge_count), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adj_clock_divider_ctrl.md
ADJ_CLOCK_DIVIDER_CTRL -- requirements
Module: adj_clock_divider_ctrl

Interface
REQ-001 SHALL have parameter INPUT_BIT_WIDTH, default 8, width of the factor and the counter.
REQ-002 SHALL have parameter RESET_FACTOR, default 255, active factor loaded at reset.
REQ-003 SHALL have port ClkInput  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port ResetN  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Enable  input  1  level; 1 = run divider, 0 = stop cleanly.
REQ-006 SHALL have port CfgValid  input  1  new factor offered.
REQ-007 SHALL have port CfgFactor  input  INPUT_BIT_WIDTH  offered factor.
REQ-008 SHALL have port CfgReady  output  1  controller accepts factor this cycle.
REQ-009 SHALL have port ClkOutput  output  1  divided clock, registered.
REQ-010 SHALL have port Tick  output  1  one-cycle pulse, registered, high in the cycle ClkOutput changes.
REQ-011 SHALL have port Busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement states IDLE, RUN, PEND, DRAIN.
REQ-013 Half-period SHALL be ActiveFactor+1 ClkInput cycles: counter increments in RUN/PEND/DRAIN; when counter >= ActiveFactor, counter <= 0, ClkOutput toggles, Tick = 1.
REQ-014 Factor 0 SHALL toggle ClkOutput every cycle (divide by 2); factor 2^W-1 SHALL work without counter overflow.
REQ-015 Config handshake: transfer when CfgValid && CfgReady; CfgReady = 1 in IDLE and RUN, 0 in PEND and DRAIN.
REQ-016 Transfer in IDLE SHALL write ActiveFactor directly the next cycle; state remains IDLE.
REQ-017 Transfer in RUN SHALL latch CfgFactor into PendingFactor and go to PEND; counting continues with old ActiveFactor.
REQ-018 In PEND, at the next toggle event ActiveFactor <= PendingFactor, counter <= 0, state <= RUN; new factor governs the very next half-period (no runt or stretched half-period mixing factors).
REQ-019 IDLE -> RUN when Enable = 1; first toggle (to 1) occurs ActiveFactor+1 cycles after entering RUN.
REQ-020 Enable = 0 in RUN/PEND with ClkOutput = 0 SHALL go to IDLE next cycle, counter cleared, no toggle.
REQ-021 Enable = 0 in RUN/PEND with ClkOutput = 1 SHALL go to DRAIN; high phase completes at full length, the 1->0 toggle occurs, then IDLE.
REQ-022 A pending factor in PEND when DRAIN/IDLE is entered SHALL still be applied to ActiveFactor on that exit (never dropped).
REQ-023 Enable returning to 1 during DRAIN SHALL be ignored until IDLE is reached; IDLE -> RUN then follows REQ-019.
REQ-024 In IDLE ClkOutput SHALL be 0, Tick 0, counter 0.
REQ-025 CfgValid && CfgReady coincident with Enable rising in IDLE: factor applied first; RUN uses the new factor.

Reset
REQ-026 ResetN = 0 SHALL immediately force state IDLE, counter 0, ActiveFactor = RESET_FACTOR, PendingFactor = 0, ClkOutput 0, Tick 0, Busy 0, CfgReady 1 (asynchronous, mid-period included).
REQ-027 Deassertion SHALL be observed at a rising ClkInput edge; first state change no earlier than the first edge after ResetN rises.

Configuration
REQ-028 Macro ADJ_CLOCK_DIVIDER_CTRL_EDGE_CNT_EN defined: SHALL add output EdgeCount [15:0], incremented on every Tick, wraps 0xFFFF -> 0, cleared by reset, held in IDLE.
REQ-029 Macro undefined: port EdgeCount and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-030 Reset, Enable=1, factor 3 via IDLE handshake -> ClkOutput high for 4, low for 4 cycles; Tick every 4 cycles; Busy=1.
REQ-031 Running factor 3, transfer factor 1 mid-high-phase -> CfgReady 0 until the toggle; high phase stays 4 cycles, subsequent phases 2 cycles.
REQ-032 Factor 0 then factor 255 -> period 2 cycles, then high/low 256 cycles each, no counter wrap glitch.
REQ-033 Enable dropped 1 cycle into high phase, factor 5 -> high lasts 6 cycles total, falls, Busy 0 next cycle; Enable dropped during low phase -> IDLE next cycle, no toggle.
REQ-034 ResetN pulsed low mid-high-phase, asynchronous to ClkInput -> ClkOutput 0 without waiting for an edge, ActiveFactor = 255.
REQ-035 With EDGE_CNT_EN, factor 0 for 65537 ticks -> EdgeCount wraps to 1; without macro the bench compiles with EdgeCount omitted.
